// File: rtl/riscv_csr_file.sv
// Machine-mode CSR file: combinational CSR read, next-edge commit, trap/MRET state and counters.
// Define RISCV_CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters and their CSR views.
module riscv_csr_file #(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [WORD_LENGTH-1:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            csr_addr,
  input  logic                   csr_we,
  input  logic [WORD_LENGTH-1:0] csr_wr_data,
  output logic [WORD_LENGTH-1:0] csr_rd_data,
  output logic                   csr_illegal,
  input  logic                   instret_inc,
  input  logic                   trap_valid,
  input  logic [WORD_LENGTH-1:0] trap_cause,
  input  logic [WORD_LENGTH-1:0] trap_pc,
  input  logic                   mret,
  output logic [WORD_LENGTH-1:0] trap_vector,
  output logic [WORD_LENGTH-1:0] epc
);

  localparam int W = WORD_LENGTH;
  localparam logic [W-1:0] ALIGN_MASK = ~{{(W-2){1'b0}}, 2'b11};

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic         mie_q, mie_d, mpie_q, mpie_d;
  logic [W-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [W-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [W-1:0] mstatus_rd;
  logic         implemented, read_only, wr_en;

`ifdef RISCV_CSR_COUNTERS_EN
  localparam logic [2*W-1:0] CNT_ONE = {{(2*W-1){1'b0}}, 1'b1};
  logic [2*W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  logic unused_instret_inc;
  assign unused_instret_inc = instret_inc;
`endif

  // MPP is hardwired to machine mode.
  assign mstatus_rd = {{(W-13){1'b0}}, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};

  always_comb begin
    csr_rd_data = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr)
      A_MSTATUS:  csr_rd_data = mstatus_rd;
      A_MISA:     csr_rd_data = MISA_VALUE;
      A_MTVEC:    csr_rd_data = mtvec_q;
      A_MSCRATCH: csr_rd_data = mscratch_q;
      A_MEPC:     csr_rd_data = mepc_q;
      A_MCAUSE:   csr_rd_data = mcause_q;
`ifdef RISCV_CSR_COUNTERS_EN
      A_MCYCLE:    csr_rd_data = mcycle_q[W-1:0];
      A_MCYCLEH:   csr_rd_data = mcycle_q[2*W-1:W];
      A_MINSTRET:  csr_rd_data = minstret_q[W-1:0];
      A_MINSTRETH: csr_rd_data = minstret_q[2*W-1:W];
      A_CYCLE: begin
        csr_rd_data = mcycle_q[W-1:0];
        read_only   = 1'b1;
      end
      A_CYCLEH: begin
        csr_rd_data = mcycle_q[2*W-1:W];
        read_only   = 1'b1;
      end
      A_INSTRET: begin
        csr_rd_data = minstret_q[W-1:0];
        read_only   = 1'b1;
      end
      A_INSTRETH: begin
        csr_rd_data = minstret_q[2*W-1:W];
        read_only   = 1'b1;
      end
`else
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH,
      A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH: csr_rd_data = '0;
`endif
      default: implemented = 1'b0;
    endcase
  end

  assign csr_illegal = ~implemented | (csr_we & read_only);
  // Trap beats MRET beats an ALU write; a losing write is simply dropped.
  assign wr_en       = csr_we & ~trap_valid & ~mret & ~csr_illegal;
  assign trap_vector = mtvec_q & ALIGN_MASK;
  assign epc         = mepc_q;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_valid) begin
      mepc_d   = trap_pc & ALIGN_MASK;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_d  = csr_wr_data[3];
          mpie_d = csr_wr_data[7];
        end
        A_MTVEC:    mtvec_d    = csr_wr_data & ALIGN_MASK;
        A_MSCRATCH: mscratch_d = csr_wr_data;
        A_MEPC:     mepc_d     = csr_wr_data & ALIGN_MASK;
        A_MCAUSE:   mcause_d   = csr_wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

`ifdef RISCV_CSR_COUNTERS_EN
  // A half-word write replaces that counter's increment; the other half holds.
  always_comb begin
    mcycle_d   = mcycle_q + CNT_ONE;
    minstret_d = minstret_q + {{(2*W-1){1'b0}}, instret_inc};
    if (wr_en) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_d   = {mcycle_q[2*W-1:W], csr_wr_data};
        A_MCYCLEH:   mcycle_d   = {csr_wr_data, mcycle_q[W-1:0]};
        A_MINSTRET:  minstret_d = {minstret_q[2*W-1:W], csr_wr_data};
        A_MINSTRETH: minstret_d = {csr_wr_data, minstret_q[W-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_csr_file.sv
// Self-checking bench for riscv_csr_file: directed literal checks plus randomized traffic
// against a behavioural model. Follows RISCV_CSR_COUNTERS_EN the same way as the design.
module tb_riscv_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
`ifdef RISCV_CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] csr_addr = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wr_data = '0;
  logic [31:0] csr_rd_data;
  logic        csr_illegal;
  logic        instret_inc = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        mret = 1'b0;
  logic [31:0] trap_vector;
  logic [31:0] epc;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  riscv_csr_file #(
    .WORD_LENGTH(32),
    .MTVEC_RESET(MTVEC_RST),
    .MISA_VALUE (MISA_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_we(csr_we),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal),
    .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .trap_vector(trap_vector), .epc(epc)
  );

  always #5 clk = ~clk;

  // Behavioural model state: architectural values only.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  function automatic logic exp_ill(input logic [11:0] a, input logic we);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b0;
      12'hC00, 12'hC80, 12'hC02, 12'hC82: return we && CNT_EN;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    logic [63:0] c, n;
    c = CNT_EN ? m_cyc : 64'd0;
    n = CNT_EN ? m_ins : 64'd0;
    case (a)
      12'h300: return 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: return MISA_VAL;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return c[31:0];
      12'hB80, 12'hC80: return c[63:32];
      12'hB02, 12'hC02: return n[31:0];
      12'hB82, 12'hC82: return n[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic wr_ok();
    return csr_we && !trap_valid && !mret && !exp_ill(csr_addr, csr_we);
  endfunction

  function automatic logic [63:0] cyc_next();
    if (CNT_EN && wr_ok() && csr_addr == 12'hB00) return {m_cyc[63:32], csr_wr_data};
    if (CNT_EN && wr_ok() && csr_addr == 12'hB80) return {csr_wr_data, m_cyc[31:0]};
    return m_cyc + 64'd1;
  endfunction

  function automatic logic [63:0] ins_next();
    if (CNT_EN && wr_ok() && csr_addr == 12'hB02) return {m_ins[63:32], csr_wr_data};
    if (CNT_EN && wr_ok() && csr_addr == 12'hB82) return {csr_wr_data, m_ins[31:0]};
    return m_ins + (instret_inc ? 64'd1 : 64'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mie <= 1'b0; m_mpie <= 1'b0;
      m_mtvec <= MTVEC_RST; m_mscratch <= '0; m_mepc <= '0; m_mcause <= '0;
      m_cyc <= '0; m_ins <= '0;
    end else begin
      m_cyc <= cyc_next();
      m_ins <= ins_next();
      if (trap_valid) begin
        m_mepc   <= trap_pc & ~32'd3;
        m_mcause <= trap_cause;
        m_mpie   <= m_mie;
        m_mie    <= 1'b0;
      end else if (mret) begin
        m_mie  <= m_mpie;
        m_mpie <= 1'b1;
      end else if (wr_ok()) begin
        case (csr_addr)
          12'h300: begin m_mie <= csr_wr_data[3]; m_mpie <= csr_wr_data[7]; end
          12'h305: m_mtvec    <= csr_wr_data & ~32'd3;
          12'h340: m_mscratch <= csr_wr_data;
          12'h341: m_mepc     <= csr_wr_data & ~32'd3;
          12'h342: m_mcause   <= csr_wr_data;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t addr=%h)", name, act, exp, $time, csr_addr);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd_data", csr_rd_data, exp_rd(csr_addr));
      chk("model_illegal", {31'd0, csr_illegal}, {31'd0, exp_ill(csr_addr, csr_we)});
      chk("model_trap_vector", trap_vector, m_mtvec & ~32'd3);
      chk("model_epc", epc, m_mepc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_we = 1'b0; trap_valid = 1'b0; mret = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle();
    csr_addr = a; csr_wr_data = d; csr_we = 1'b1;
    $display("write  addr=%h data=%h", a, d);
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_we = 1'b0; csr_addr = a;
    #1;
    $display("read   addr=%h data=%h illegal=%b", a, csr_rd_data, csr_illegal);
    chk(name, csr_rd_data, exp);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd("rst_mtvec", 12'h305, 32'h0000_1003);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);
    rd("rst_mscratch", 12'h340, 32'h0);
    chk("rst_trap_vector", trap_vector, 32'h0000_1000);

    wr(12'h341, 32'hDEAD_BEEF); tick(); idle();
    rd("mepc_warl", 12'h341, 32'hDEAD_BEEC);
    chk("epc_port", epc, 32'hDEAD_BEEC);
    wr(12'h300, 32'h0000_0088); tick(); idle();
    rd("mstatus_warl", 12'h300, 32'h0000_1888);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("unimpl_rd", 12'h7C0, 32'h0);
    chk("unimpl_illegal", {31'd0, csr_illegal}, 32'd1);

    trap_valid = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'h0000_000B;
    $display("trap   pc=%h cause=%h", trap_pc, trap_cause);
    tick(); idle();
    rd("trap_mcause", 12'h342, 32'h0000_000B);
    chk("trap_epc", epc, 32'h0000_0100);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    mret = 1'b1; $display("mret");
    tick(); idle();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    wr(12'h340, 32'h0000_0077); tick(); idle();
    wr(12'h340, 32'h0000_0005);
    trap_valid = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0204; trap_cause = 32'h0000_0003;
    $display("trap+mret+write same cycle");
    tick(); idle();
    rd("prio_mscratch", 12'h340, 32'h0000_0077);
    rd("prio_mepc", 12'h341, 32'h0000_0204);
    rd("prio_mcause", 12'h342, 32'h0000_0003);
    rd("prio_mstatus", 12'h300, 32'h0000_1880);

`ifdef RISCV_CSR_COUNTERS_EN
    wr(12'hB82, 32'h0); tick();
    wr(12'hB02, 32'h0000_0100); tick(); idle();
    instret_inc = 1'b1;
    repeat (3) tick();
    instret_inc = 1'b0;
    rd("minstret_plus3", 12'hB02, 32'h0000_0103);
    rd("minstreth", 12'hB82, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFF); tick();
    wr(12'hB80, 32'hFFFF_FFFF); tick(); idle();
    tick();
    rd("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd("mcycle_wrap_hi", 12'hB80, 32'h0);
    wr(12'hB00, 32'h0000_0050); tick();
    wr(12'hC00, 32'h0);
    #1 chk("ro_write_illegal", {31'd0, csr_illegal}, 32'd1);
    tick(); idle();
    rd("cycle_unaffected", 12'hC00, 32'h0000_0051);
`else
    wr(12'hB00, 32'h0000_0050); tick(); idle();
    rd("cnt_off_mcycle", 12'hB00, 32'h0);
    chk("cnt_off_legal", {31'd0, csr_illegal}, 32'd0);
    wr(12'hC00, 32'h0);
    #1 chk("cnt_off_ro_legal", {31'd0, csr_illegal}, 32'd0);
    tick(); idle();
`endif

    for (int i = 0; i < 3000; i++) begin
      tick();
      case ($urandom_range(0, 15))
        0:  csr_addr = 12'h300;  1: csr_addr = 12'h301;  2: csr_addr = 12'h305;
        3:  csr_addr = 12'h340;  4: csr_addr = 12'h341;  5: csr_addr = 12'h342;
        6:  csr_addr = 12'hB00;  7: csr_addr = 12'hB80;  8: csr_addr = 12'hB02;
        9:  csr_addr = 12'hB82;  10: csr_addr = 12'hC00; 11: csr_addr = 12'hC80;
        12: csr_addr = 12'hC02;  13: csr_addr = 12'hC82; 14: csr_addr = 12'h7C0;
        default: csr_addr = 12'($urandom);
      endcase
      csr_we      = ($urandom_range(0, 1) == 1);
      csr_wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      instret_inc = ($urandom_range(0, 1) == 1);
      trap_valid  = ($urandom_range(0, 7) == 0);
      mret        = ($urandom_range(0, 7) == 0);
      trap_pc     = $urandom;
      trap_cause  = $urandom;
      $display("rand   addr=%h we=%b data=%h trap=%b mret=%b inc=%b",
               csr_addr, csr_we, csr_wr_data, trap_valid, mret, instret_inc);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        $display("async reset pulse");
        #1 rst_n = 1'b1;
      end
    end

    idle();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_csr_file.md
Name: riscv_csr_file

Overview:
Machine-mode CSR register file; the storage end of the CSR datapath.
- Supplies the current CSR value (csr_rd_data) to the CSR ALU.
- Commits the ALU result (csr_wr_data) on the next clock edge.
- Owns the trap-entry/MRET state updates and the cycle/instret counters.
- Sits in the execute/writeback stage beside the integer register file.

Parameters:
WORD_LENGTH, 32, data width of CSRs (only 32 supported)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
MISA_VALUE, 32'h4000_0100, constant returned for misa (RV32I)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
csr_addr  input  12  CSR address of current instruction
csr_we  input  1  commit csr_wr_data to csr_addr at next edge
csr_wr_data  input  WORD_LENGTH  new value from CSR ALU
csr_rd_data  output  WORD_LENGTH  current value at csr_addr (combinational)
csr_illegal  output  1  csr_addr unimplemented, or write to read-only CSR
instret_inc  input  1  one instruction retired this cycle
trap_valid  input  1  take trap this cycle
trap_cause  input  WORD_LENGTH  value for mcause
trap_pc  input  WORD_LENGTH  PC of trapping instruction
mret  input  1  MRET retiring this cycle
trap_vector  output  WORD_LENGTH  {mtvec[31:2],2'b00} (direct mode only)
epc  output  WORD_LENGTH  current mepc

Behaviour:
- Read: csr_rd_data is combinational from csr_addr, zero latency. Unimplemented address reads 0 and raises csr_illegal.
- Write: when csr_we=1 and the address is legal and writable, the register updates at the rising clk edge. Writes to read-only CSRs set csr_illegal and are dropped.
- Implemented CSRs (WARL masks applied on write):
  - mstatus 0x300: MIE[3] and MPIE[7] writable. MPP[12:11] reads 2'b11. Other bits read 0.
  - misa 0x301: reads MISA_VALUE. Writes ignored and not illegal.
  - mtvec 0x305: bits[1:0] forced to 0.
  - mscratch 0x340: full width.
  - mepc 0x341: bits[1:0] forced to 0.
  - mcause 0x342: full width.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: read/write.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases.
- Reset values:
  - mstatus = 0 (MPP still reads 11).
  - mtvec = MTVEC_RESET.
  - mscratch, mepc, mcause = 0.
  - Counters = 0.
  - Outputs follow their registers immediately after reset.
- Counters:
  - 64-bit mcycle increments every cycle out of reset.
  - 64-bit minstret increments when instret_inc=1.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to either half of a counter in a cycle overrides that counter's increment for that cycle; the other half retains its value.
- Trap entry (trap_valid=1), at the next edge:
  - mepc ← trap_pc & ~3
  - mcause ← trap_cause
  - MPIE ← MIE, MIE ← 0
- MRET (mret=1), at the next edge: MIE ← MPIE, MPIE ← 1.
- Priority in the same cycle: trap_valid > mret > csr_we.
  - A dropped write or MRET has no effect.
  - Counters still increment when a trap is taken.
- Reset mid-operation: rst_n low asynchronously clears all state regardless of pending inputs.

Optional Feature:
RISCV_CSR_COUNTERS_EN
- Defined: the counter CSRs behave as above.
- Undefined:
  - No counter registers are instantiated.
  - Counter addresses read 0.
  - Writes to them are ignored.
  - csr_illegal is not raised for them.
  - instret_inc is unused.

Test Plan:
- Reset: rst_n=0 then 1 → mtvec reads MTVEC_RESET; mstatus reads 32'h0000_1800; mepc, mcause, mscratch read 0; trap_vector=MTVEC_RESET&~3.
- Write/readback: write 32'hDEAD_BEEF to 0x341 → reads 32'hDEAD_BEEC next cycle; write 32'h0000_0088 to 0x300 → reads 32'h0000_1888.
- Illegal: read 0x7C0 → csr_rd_data=0, csr_illegal=1; write 0xC00 → csr_illegal=1, cycle unaffected.
- Trap then MRET: with MIE=1, trap_valid, trap_pc=32'h0000_0103, trap_cause=32'h0000_000B → epc=32'h0000_0100, mcause=11, MIE=0, MPIE=1. Then mret → MIE=1, MPIE=1.
- Priority: trap_valid, mret and csr_we (mscratch←5) all in one cycle → trap effects only; mscratch unchanged.
- Counters (macro defined):
  - Write 32'hFFFF_FFFF to 0xB00 and 0xB80 → next cycle mcycle reads 0 and mcycleh reads 0 (wrap).
  - 3 cycles with instret_inc=1 → minstret increases by 3.
